// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative EX-stage multiply/divide unit for the MIPS pipeline.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring division. Each takes
// one PREP cycle, WIDTH RUN cycles and one FIX cycle, then writes HI/LO.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

  state_t             state_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  // Multiplicand for multiply, divisor for divide (magnitude form).
  logic [WIDTH-1:0]   mcand_q;
  // Multiply: {partial product, remaining multiplier}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  // neg_lo_q: sign of product or quotient; neg_hi_q: sign of remainder.
  logic               neg_lo_q, neg_hi_q;
  logic               busy_q, done_q, dbz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               is_div, is_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] mul_step, div_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];

  // Operand magnitudes, one iteration step for each operation, and final sign fixup.
  always_comb begin
    a_mag     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_step  = {mul_sum, acc_q[WIDTH-1:1]};

    // Trial-subtract from the remainder shifted left by one (top WIDTH+1 bits).
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q};
    if (!div_trial[WIDTH])
      div_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      div_step = {acc_q[2*WIDTH-2:0], 1'b0};

    prod_fix  = neg_lo_q ? -acc_q : acc_q;
    quo_fix   = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Control FSM with datapath registers; start is only looked at in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          neg_lo_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_hi_q <= is_signed & is_div & a_q[WIDTH-1];
          mcand_q  <= is_div ? b_mag : a_mag;
          acc_q    <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
          cnt_q    <= '0;
          state_q  <= S_RUN;
        end
        S_RUN: begin
          acc_q <= is_div ? div_step : mul_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1))
            state_q <= S_FIX;
        end
        S_FIX: begin
          if (is_div && (b_q == '0)) begin
            hi_q  <= a_q;
            lo_q  <= '1;
            dbz_q <= 1'b1;
          end else if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Freeze upstream stages from the accepting cycle through the last RUN cycle.
  assign stall       = (start && (state_q == S_IDLE)) || (state_q == S_PREP) || (state_q == S_RUN);
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: a countdown/arithmetic reference model
// checked every cycle, plus directed operations with hand-computed results.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        stall, busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Arithmetic reference: {div_by_zero, hi, lo}.
  function automatic logic [64:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] u, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin u = {32'b0, x} * {32'b0, y}; return {1'b0, u}; end
      2'b01: begin u = sx * sy; return {1'b0, u}; end
      default: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFFFFFF};
        if (o == 2'b10) return {1'b0, x % y, x / y};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Timing model: an accepted op occupies 34 cycles; results land on the last edge.
  int          m_rem = 0;
  logic        m_done = 1'b0, m_dbz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [64:0] m_pend = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (m_rem == 0) begin
        if (start) begin
          m_rem  <= 34;
          m_pend <= ref_result(op, a, b);
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done <= 1'b1;
          m_dbz  <= m_pend[64];
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled away from the rising edge.
  always @(negedge clk) begin
    chk("m_stall", {63'b0, stall}, {63'b0, ((start && m_rem == 0) || m_rem > 1)});
    chk("m_busy",  {63'b0, busy},  {63'b0, (m_rem > 0)});
    chk("m_done",  {63'b0, done},  {63'b0, m_done});
    chk("m_dbz",   {63'b0, div_by_zero}, {63'b0, m_dbz});
    chk("m_hilo",  {hi, lo}, {m_hi, m_lo});
  end

  // Issue one op with start held through FIX; start drops just after the write edge.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz, input bit scramble);
    int stall_cnt = 0, busy_cnt = 0, done_cnt = 0, done_k = -1;
    logic        dbz_at = 1'b0;
    logic [31:0] hi_at = '0, lo_at = '0;
    @(negedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    #1;
    if (stall) stall_cnt++;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_k = k;
        dbz_at = div_by_zero;
        hi_at  = hi;
        lo_at  = lo;
      end
      if (scramble && (k == 10 || k == 20)) begin
        a = $urandom;
        b = $urandom;
      end
      if (k == 34) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    chk({name, "_hi"},      {32'b0, hi_at}, {32'b0, exp_hi});
    chk({name, "_lo"},      {32'b0, lo_at}, {32'b0, exp_lo});
    chk({name, "_dbz"},     {63'b0, dbz_at}, {63'b0, exp_dbz});
    chk({name, "_ndone"},   64'(done_cnt), 64'd1);
    chk({name, "_latency"}, 64'(done_k), 64'd35);
    chk({name, "_stall"},   64'(stall_cnt), 64'd34);
    chk({name, "_busy"},    64'(busy_cnt), 64'd34);
  endtask

  initial begin
    int done_cnt;
    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    start = 1'b1; #1;
    chk("rst_stall_eq_start", {63'b0, stall}, 64'd1);
    @(negedge clk);
    chk("rst_no_accept", {63'b0, busy}, 64'd0);
    start = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;

    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    run_op("mult_neg",  2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
    run_op("div_neg",   2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("div_negb",  2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("divu",      2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0);
    run_op("div_ovf",   2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
    run_op("divu_zero", 2'b10, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("held_start",2'b10, 32'd1000,     32'd9,        32'd1,        32'd111,      1'b0, 1'b1);

    // Abort a multiply partway through RUN with an asynchronous reset.
    @(negedge clk); #1;
    start = 1'b1; op = 2'b00; a = 32'hDEADBEEF; b = 32'h00012345;
    repeat (12) @(negedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    #1;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk); #1;
    rst = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_hilo_after", {hi, lo}, 64'd0);

    run_op("multu_6x7", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
